// File: rtl/flags_update_unit.sv
// flags_update_unit: two-stage pipeline computing x86-style arithmetic
// results and a masked write into the flags register, including POPF.
module flags_update_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [1:0]  in_size,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [1:0]  in_cpl,
  input  logic [31:0] EFLAGS,
  output logic        write_enable,
  output logic [31:0] write_data,
  output logic [31:0] write_mask,
  output logic [31:0] result,
  output logic        gp_fault
);

  localparam int unsigned W = 32;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_ADC   = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_SBB   = 3'd3;
  localparam logic [2:0] OP_LOGIC = 3'd4;
  localparam logic [2:0] OP_INC   = 3'd5;
  localparam logic [2:0] OP_DEC   = 3'd6;
  localparam logic [2:0] OP_POPF  = 3'd7;

  localparam logic [W-1:0] MASK_ARITH  = 32'h0000_08D5;
  localparam logic [W-1:0] MASK_INCDEC = 32'h0000_08D4;
  localparam logic [W-1:0] MASK_POPF   = 32'h0000_4DD5;
  localparam logic [W-1:0] DATA_FIXED  = 32'h0000_0002;
  localparam logic [W-1:0] RF_BIT      = 32'h0001_0000;

  // stage 1 state
  logic         s1_valid_q, s1_valid_d;
  logic [2:0]   s1_op_q,    s1_op_d;
  logic [1:0]   s1_size_q,  s1_size_d;
  logic [W-1:0] s1_a_q,     s1_a_d;
  logic [W-1:0] s1_b_q,     s1_b_d;
  logic [W:0]   s1_sum_q,   s1_sum_d;
  logic [1:0]   s1_cpl_q,   s1_cpl_d;
  logic [1:0]   s1_iopl_q,  s1_iopl_d;
  logic         s1_vm_q,    s1_vm_d;

  // stage 2 / output state
  logic         s2_valid_q,     s2_valid_d;
  logic         write_enable_q, write_enable_d;
  logic [W-1:0] write_data_q,   write_data_d;
  logic [W-1:0] write_mask_q,   write_mask_d;
  logic [W-1:0] result_q,       result_d;
  logic         gp_fault_q,     gp_fault_d;

  logic         accept;
  logic         hazard_op;
  logic [W-1:0] in_size_mask;
  logic [W-1:0] a_trunc;
  logic [W-1:0] b_trunc;
  logic [W-1:0] b_eff;
  logic         carry_in;
  logic         is_sub;

  logic [W-1:0] s2_size_mask;
  logic [W-1:0] r_val;
  logic [W-1:0] flags;
  logic [W-1:0] popf_mask;
  logic         a_msb, b_msb, r_msb, cf, zf, sf, pf, af, of_flag;
  logic         popf_fault;

  logic         unused_eflags;
  assign unused_eflags = ^{EFLAGS[31:18], EFLAGS[16:14], EFLAGS[11:1]};

  // ADC/SBB/POPF read flags, so they wait until no earlier op can still write them
  always_comb begin
    hazard_op = (in_op == OP_ADC) || (in_op == OP_SBB) || (in_op == OP_POPF);
    in_ready  = !(hazard_op && (s1_valid_q || s2_valid_q));
    accept    = in_valid && in_ready;
  end

  // stage 1: operand truncation and (n+1)-bit sum/difference
  always_comb begin
    in_size_mask = 32'hFFFF_FFFF;
    case (in_size)
      2'd0:    in_size_mask = 32'h0000_00FF;
      2'd1:    in_size_mask = 32'h0000_FFFF;
      default: in_size_mask = 32'hFFFF_FFFF;
    endcase
    a_trunc  = in_a & in_size_mask;
    b_trunc  = in_b & in_size_mask;
    b_eff    = b_trunc;
    carry_in = 1'b0;
    is_sub   = 1'b0;
    case (in_op)
      OP_ADC: carry_in = EFLAGS[0];
      OP_SUB: is_sub   = 1'b1;
      OP_SBB: begin is_sub = 1'b1; carry_in = EFLAGS[0]; end
      OP_INC: b_eff    = 32'h0000_0001;
      OP_DEC: begin is_sub = 1'b1; b_eff = 32'h0000_0001; end
      default: ;
    endcase

    s1_valid_d = accept;
    s1_op_d    = in_op;
    s1_size_d  = in_size;
    s1_a_d     = a_trunc;
    s1_b_d     = b_eff;
    s1_cpl_d   = in_cpl;
    s1_iopl_d  = EFLAGS[13:12];
    s1_vm_d    = EFLAGS[17];
    if (is_sub) begin
      s1_sum_d = {1'b0, a_trunc} - {1'b0, b_eff} - (W+1)'(carry_in);
    end else begin
      s1_sum_d = {1'b0, a_trunc} + {1'b0, b_eff} + (W+1)'(carry_in);
    end
    if (in_op == OP_LOGIC) begin
      s1_sum_d = {1'b0, b_trunc};
    end else if (in_op == OP_POPF) begin
      s1_a_d   = in_a;
      s1_sum_d = '0;
    end
  end

  // stage 2: flag derivation, write mask and registered outputs
  always_comb begin
    s2_size_mask = 32'hFFFF_FFFF;
    a_msb = s1_a_q[31];
    b_msb = s1_b_q[31];
    r_msb = s1_sum_q[31];
    cf    = s1_sum_q[32];
    case (s1_size_q)
      2'd0: begin
        s2_size_mask = 32'h0000_00FF;
        a_msb = s1_a_q[7];  b_msb = s1_b_q[7];  r_msb = s1_sum_q[7];  cf = s1_sum_q[8];
      end
      2'd1: begin
        s2_size_mask = 32'h0000_FFFF;
        a_msb = s1_a_q[15]; b_msb = s1_b_q[15]; r_msb = s1_sum_q[15]; cf = s1_sum_q[16];
      end
      default: ;
    endcase
    r_val = s1_sum_q[W-1:0] & s2_size_mask;
    zf    = (r_val == '0);
    sf    = r_msb;
    pf    = ~^r_val[7:0];
    af    = s1_a_q[4] ^ s1_b_q[4] ^ r_val[4];
    if ((s1_op_q == OP_SUB) || (s1_op_q == OP_SBB) || (s1_op_q == OP_DEC)) begin
      of_flag = (a_msb != b_msb) && (r_msb != a_msb);
    end else begin
      of_flag = (a_msb == b_msb) && (r_msb != a_msb);
    end
    if (s1_op_q == OP_LOGIC) begin
      cf = 1'b0; af = 1'b0; of_flag = 1'b0;
    end
    flags     = '0;
    flags[0]  = cf;
    flags[2]  = pf;
    flags[4]  = af;
    flags[6]  = zf;
    flags[7]  = sf;
    flags[11] = of_flag;

    // POPF: IF needs cpl <= IOPL, IOPL only at cpl 0, RF only for dword, VM never
    popf_mask = MASK_POPF;
    if (s1_cpl_q <= s1_iopl_q) popf_mask[9] = 1'b1;
    if (s1_cpl_q == 2'd0)      popf_mask[13:12] = 2'b11;
    if (s1_size_q[1])          popf_mask[16] = 1'b1;
    popf_fault = s1_vm_q && (s1_iopl_q != 2'd3);

    s2_valid_d     = s1_valid_q;
    write_enable_d = 1'b0;
    write_data_d   = DATA_FIXED;
    write_mask_d   = '0;
    result_d       = '0;
    gp_fault_d     = 1'b0;
    if (s1_valid_q) begin
      case (s1_op_q)
        OP_POPF: begin
          if (popf_fault) begin
            gp_fault_d = 1'b1;
          end else begin
            write_enable_d = 1'b1;
            write_mask_d   = popf_mask;
            write_data_d   = (s1_a_q & popf_mask & ~RF_BIT) | DATA_FIXED;
          end
        end
        OP_INC, OP_DEC: begin
          write_enable_d = 1'b1;
          write_mask_d   = MASK_INCDEC;
          write_data_d   = (flags & MASK_INCDEC) | DATA_FIXED;
          result_d       = r_val;
        end
        default: begin
          write_enable_d = 1'b1;
          write_mask_d   = MASK_ARITH;
          write_data_d   = (flags & MASK_ARITH) | DATA_FIXED;
          result_d       = r_val;
        end
      endcase
    end
  end

  // pipeline registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q     <= 1'b0;
      s1_op_q        <= '0;
      s1_size_q      <= '0;
      s1_a_q         <= '0;
      s1_b_q         <= '0;
      s1_sum_q       <= '0;
      s1_cpl_q       <= '0;
      s1_iopl_q      <= '0;
      s1_vm_q        <= 1'b0;
      s2_valid_q     <= 1'b0;
      write_enable_q <= 1'b0;
      write_data_q   <= DATA_FIXED;
      write_mask_q   <= '0;
      result_q       <= '0;
      gp_fault_q     <= 1'b0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_op_q        <= s1_op_d;
      s1_size_q      <= s1_size_d;
      s1_a_q         <= s1_a_d;
      s1_b_q         <= s1_b_d;
      s1_sum_q       <= s1_sum_d;
      s1_cpl_q       <= s1_cpl_d;
      s1_iopl_q      <= s1_iopl_d;
      s1_vm_q        <= s1_vm_d;
      s2_valid_q     <= s2_valid_d;
      write_enable_q <= write_enable_d;
      write_data_q   <= write_data_d;
      write_mask_q   <= write_mask_d;
      result_q       <= result_d;
      gp_fault_q     <= gp_fault_d;
    end
  end

  assign write_enable = write_enable_q;
  assign write_data   = write_data_q;
  assign write_mask   = write_mask_q;
  assign result       = result_q;
  assign gp_fault     = gp_fault_q;

endmodule

// File: tb/tb_flags_update_unit.sv
// Directed testbench for flags_update_unit with a flags-register model.
module tb_flags_update_unit;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [1:0]  in_size;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [1:0]  in_cpl;
  logic [31:0] eflags;
  logic        write_enable;
  logic [31:0] write_data;
  logic [31:0] write_mask;
  logic [31:0] result;
  logic        gp_fault;

  logic        load_en;
  logic [31:0] load_val;

  int n_checks = 0;
  int n_errors = 0;

  flags_update_unit dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_size      (in_size),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_cpl       (in_cpl),
    .EFLAGS       (eflags),
    .write_enable (write_enable),
    .write_data   (write_data),
    .write_mask   (write_mask),
    .result       (result),
    .gp_fault     (gp_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // flags register fed by the unit's masked write port
  always @(posedge clock) begin
    if (load_en) eflags <= load_val;
    else if (write_enable) eflags <= (eflags & ~write_mask) | (write_data & write_mask);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [1:0] size,
                       input logic [31:0] a, input logic [31:0] b, input logic [1:0] cpl);
    in_op = op; in_size = size; in_a = a; in_b = b; in_cpl = cpl; in_valid = 1'b1;
  endtask

  // issue one op, wait (bounded) for acceptance, return in its write_enable cycle
  task automatic run_op(input string tag, input logic [2:0] op, input logic [1:0] size,
                        input logic [31:0] a, input logic [31:0] b, input logic [1:0] cpl);
    int k;
    @(negedge clock);
    drive(op, size, a, b, cpl);
    k = 0;
    while (!in_ready && k < 8) begin
      @(negedge clock);
      k++;
    end
    check_eq({tag, "_ready"}, 32'(in_ready), 32'd1);
    @(posedge clock);
    #1 in_valid = 1'b0;
    @(negedge clock);
    check_eq({tag, "_we_early"}, 32'(write_enable), 32'd0);
    @(negedge clock);
  endtask

  task automatic check_out(input string tag, input logic [31:0] res,
                           input logic [31:0] data, input logic [31:0] mask);
    check_eq({tag, "_we"}, 32'(write_enable), 32'd1);
    check_eq({tag, "_gp"}, 32'(gp_fault), 32'd0);
    check_eq({tag, "_result"}, result, res);
    check_eq({tag, "_data"}, write_data, data);
    check_eq({tag, "_mask"}, write_mask, mask);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_we"}, 32'(write_enable), 32'd0);
    check_eq({tag, "_mask"}, write_mask, 32'h0);
    check_eq({tag, "_data"}, write_data, 32'h2);
    check_eq({tag, "_result"}, result, 32'h0);
    check_eq({tag, "_gp"}, 32'(gp_fault), 32'd0);
    check_eq({tag, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic set_flags(input logic [31:0] v);
    @(negedge clock);
    load_en = 1'b1; load_val = v;
    @(posedge clock);
    #1 load_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    load_en = 1'b1; load_val = 32'h0000_0002;
    drive(3'd0, 2'd0, 32'h1, 32'h1, 2'd0);   // offered during reset, must be dropped
    repeat (2) @(posedge clock);
    #1 load_en = 1'b0;
    @(negedge clock);
    check_reset_vals("reset");
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    check_eq("reset_drop1_we", 32'(write_enable), 32'd0);
    @(negedge clock);
    check_eq("reset_drop2_we", 32'(write_enable), 32'd0);

    // ADD byte FF+01
    run_op("add_byte", 3'd0, 2'd0, 32'h0000_00FF, 32'h0000_0001, 2'd0);
    check_out("add_byte", 32'h0, 32'h0000_0057, 32'h0000_08D5);

    // SUB dword 0x80000000 - 1
    run_op("sub_dword", 3'd2, 2'd2, 32'h8000_0000, 32'h0000_0001, 2'd0);
    check_out("sub_dword", 32'h7FFF_FFFF, 32'h0000_0816, 32'h0000_08D5);

    // two independent ADDs on consecutive cycles
    @(negedge clock);
    drive(3'd0, 2'd0, 32'h1, 32'h2, 2'd0);
    @(posedge clock);
    #1 drive(3'd0, 2'd0, 32'h3, 32'h4, 2'd0);
    @(negedge clock);
    check_eq("tput_ready", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1 in_valid = 1'b0;
    @(negedge clock);
    check_eq("tput1_we", 32'(write_enable), 32'd1);
    check_eq("tput1_result", result, 32'h3);
    check_eq("tput1_data", write_data, 32'h6);
    @(negedge clock);
    check_eq("tput2_we", 32'(write_enable), 32'd1);
    check_eq("tput2_result", result, 32'h7);

    // ADD then ADC back-to-back: ADC stalls two cycles and sees the new CF
    @(negedge clock);
    drive(3'd0, 2'd0, 32'h0000_00FF, 32'h0000_0001, 2'd0);
    @(posedge clock);
    #1 drive(3'd1, 2'd1, 32'h0000_1234, 32'h0000_0001, 2'd0);
    @(negedge clock);
    check_eq("adc_stall1", 32'(in_ready), 32'd0);
    @(negedge clock);
    check_eq("adc_stall2", 32'(in_ready), 32'd0);
    check_eq("adc_prev_we", 32'(write_enable), 32'd1);
    @(negedge clock);
    check_eq("adc_go", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1 in_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check_out("adc", 32'h0000_1236, 32'h0000_0006, 32'h0000_08D5);

    // INC byte 0x7F: overflow into sign, CF untouched
    run_op("inc", 3'd5, 2'd0, 32'h0000_007F, 32'h0, 2'd0);
    check_out("inc", 32'h0000_0080, 32'h0000_0892, 32'h0000_08D4);

    // DEC word 0 wraps to 0xFFFF
    run_op("dec", 3'd6, 2'd1, 32'h0000_0000, 32'h0, 2'd0);
    check_out("dec", 32'h0000_FFFF, 32'h0000_0096, 32'h0000_08D4);

    // LOGIC dword zero result, and byte result truncated from in_b
    run_op("logic_z", 3'd4, 2'd2, 32'hDEAD_BEEF, 32'h0000_0000, 2'd0);
    check_out("logic_z", 32'h0, 32'h0000_0046, 32'h0000_08D5);
    run_op("logic_b", 3'd4, 2'd0, 32'h0, 32'h1234_5681, 2'd0);
    check_out("logic_b", 32'h0000_0081, 32'h0000_0086, 32'h0000_08D5);

    // SUB byte with borrow, upper operand bits ignored
    run_op("sub_borrow", 3'd2, 2'd0, 32'hABCD_0000, 32'h0000_0001, 2'd0);
    check_out("sub_borrow", 32'h0000_00FF, 32'h0000_0097, 32'h0000_08D5);

    // SBB word with CF=1 from previous op
    run_op("sbb", 3'd3, 2'd1, 32'h0000_0005, 32'h0000_0003, 2'd0);
    check_out("sbb", 32'h0000_0001, 32'h0000_0002, 32'h0000_08D5);

    // POPF dword, cpl 3, IOPL 0
    set_flags(32'h0000_0002);
    run_op("popf_d", 3'd7, 2'd2, 32'hFFFF_FFFF, 32'h0, 2'd3);
    check_out("popf_d", 32'h0, 32'h0000_4DD7, 32'h0001_4DD5);

    // POPF word, cpl 0: IF and IOPL writable, upper half excluded
    set_flags(32'h0000_0002);
    run_op("popf_w", 3'd7, 2'd1, 32'hFFFF_FFFF, 32'h0, 2'd0);
    check_out("popf_w", 32'h0, 32'h0000_7FD7, 32'h0000_7FD5);

    // POPF in VM with IOPL 2 faults
    set_flags(32'h0002_2002);
    run_op("popf_gp", 3'd7, 2'd2, 32'h0000_0000, 32'h0, 2'd3);
    check_eq("popf_gp_pulse", 32'(gp_fault), 32'd1);
    check_eq("popf_gp_we", 32'(write_enable), 32'd0);
    @(negedge clock);
    check_eq("popf_gp_end", 32'(gp_fault), 32'd0);
    check_eq("popf_gp_we2", 32'(write_enable), 32'd0);

    // reset one cycle after accepting ADD kills it
    set_flags(32'h0000_0002);
    @(negedge clock);
    drive(3'd0, 2'd0, 32'h0000_00FF, 32'h0000_0001, 2'd0);
    @(posedge clock);
    #1 in_valid = 1'b0; reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check_reset_vals("midreset");
    reset = 1'b0;
    @(negedge clock);
    check_eq("midreset_we1", 32'(write_enable), 32'd0);
    @(negedge clock);
    check_eq("midreset_we2", 32'(write_enable), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
